// File: rtl/uart_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_serializer
// Brief    : Pops bytes from the TX FIFO and shifts them out as UART frames,
//            one bit per baud tick.
// Revision : 1.0
//==============================================================================
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 tick,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int c_cnt_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_last_stop = c_cnt_w'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [c_cnt_w-1:0]     r_cnt,   w_cnt_nxt;
    logic                   r_parity, w_parity_nxt;
    logic                   r_tx,     w_tx_nxt;
    logic                   r_rd_en,  w_rd_en_nxt;
    logic                   r_tx_done, w_done_nxt;

    // Frame state only advances on baud ticks; tx_done self-clears every clk.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (tick) begin
                r_state   <= w_state_nxt;
                r_shift   <= w_shift_nxt;
                r_cnt     <= w_cnt_nxt;
                r_parity  <= w_parity_nxt;
                r_tx      <= w_tx_nxt;
                r_rd_en   <= w_rd_en_nxt;
                r_tx_done <= w_done_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_parity_nxt = r_parity;
        w_tx_nxt     = r_tx;
        w_rd_en_nxt  = r_rd_en;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    w_state_nxt = S_FETCH;
                    w_rd_en_nxt = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
                w_rd_en_nxt = 1'b0;
            end
            S_LOAD: begin
                w_shift_nxt  = fifo_data;
                w_parity_nxt = (PARITY_ODD != 0);
                w_tx_nxt     = 1'b0;
                w_state_nxt  = S_START;
            end
            S_START: begin
                w_tx_nxt     = r_shift[0];
                w_shift_nxt  = r_shift >> 1;
                w_parity_nxt = r_parity ^ r_shift[0];
                w_cnt_nxt    = '0;
                w_state_nxt  = S_DATA;
            end
            S_DATA: begin
                // Bit 0 already left in START, so DATA_BITS-1 more bits go out here.
                if (r_cnt != c_last_bit) begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_tx_nxt     = r_shift[0];
                    w_shift_nxt  = r_shift >> 1;
                    w_parity_nxt = r_parity ^ r_shift[0];
                end else if (PARITY_EN != 0) begin
                    w_tx_nxt    = r_parity;
                    w_state_nxt = S_PARITY;
                end else begin
                    w_tx_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_cnt == c_last_stop) begin
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    if (!fifo_empty) begin
                        w_state_nxt = S_FETCH;
                        w_rd_en_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_rd_en_nxt = 1'b0;
            end
        endcase
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign tx_done    = r_tx_done;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Four serializer configurations driven in lockstep from a queue
//            FIFO, each checked every clk against a frame-position model.
// Revision : 1.0
//==============================================================================
module tb_uart_tx_serializer;

    logic       clk;
    logic       areset;
    logic       tick;
    logic       wr_en;
    logic [7:0] wr_byte;
    logic       rec_on;
    int         n_cmp;
    int         n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int DB = (g == 3) ? 5 : 8;
        localparam int PE = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 1 || g == 3) ? 2 : 1;
        // Frame positions: fetch, load, start, data, optional parity, stops.
        localparam int L  = 3 + DB + PE + SB;

        logic          fifo_empty;
        logic [DB-1:0] fifo_data;
        logic          fifo_rd_en, tx, busy, tx_done;
        logic [DB-1:0] fifo_q[$];
        logic [DB-1:0] sb_q[$];
        logic [DB-1:0] fifo_reg, m_byte;
        logic          m_active, m_done, prev_empty, prev_rd;
        int            m_pos;
        logic [63:0]   rec;
        int            dcnt;
        logic [3:0]    exp_o;

        uart_tx_serializer #(
            .DATA_BITS (DB),
            .PARITY_EN (PE),
            .PARITY_ODD(PO),
            .STOP_BITS (SB)
        ) u_dut (
            .clk       (clk),
            .areset    (areset),
            .tick      (tick),
            .fifo_empty(fifo_empty),
            .fifo_data (fifo_data),
            .fifo_rd_en(fifo_rd_en),
            .tx        (tx),
            .busy      (busy),
            .tx_done   (tx_done)
        );

        function automatic logic line_bit(input int p, input logic [DB-1:0] b);
            logic [DB-1:0] t;
            if (p < 2) return 1'b1;
            if (p == 2) return 1'b0;
            if (p < 3 + DB) begin
                t = b >> (p - 3);
                return t[0];
            end
            if (PE != 0 && p == 3 + DB) return (^b) ^ (PO != 0);
            return 1'b1;
        endfunction

        initial begin
            fifo_empty = 1'b1;
            fifo_data  = '0;
            fifo_reg   = '0;
            m_byte     = '0;
            m_active   = 1'b0;
            m_done     = 1'b0;
            m_pos      = 0;
            prev_empty = 1'b1;
            prev_rd    = 1'b0;
            rec        = '0;
            dcnt       = 0;
            forever begin
                @(posedge clk);
                #1;
                if (areset) begin
                    m_active = 1'b0;
                    m_pos    = 0;
                    fifo_q.delete();
                    sb_q.delete();
                    fifo_empty = 1'b1;
                    prev_empty = 1'b1;
                    prev_rd    = 1'b0;
                    check($sformatf("cfg%0d reset outputs {busy,rd,tx,done}", g),
                          32'({busy, fifo_rd_en, tx, tx_done}), 32'h2);
                end else begin
                    if (tick && prev_rd) begin
                        if (fifo_q.size() == 0)
                            check($sformatf("cfg%0d pop while empty", g), 32'd1, 32'd0);
                        else
                            fifo_reg = fifo_q.pop_front();
                    end
                    if (wr_en) begin
                        fifo_q.push_back(wr_byte[DB-1:0]);
                        sb_q.push_back(wr_byte[DB-1:0]);
                    end
                    m_done = 1'b0;
                    if (tick) begin
                        if (m_active && m_pos < L - 1) begin
                            m_pos++;
                        end else begin
                            if (m_active) m_done = 1'b1;
                            if (!prev_empty) begin
                                m_active = 1'b1;
                                m_pos    = 0;
                                if (sb_q.size() != 0) m_byte = sb_q.pop_front();
                            end else begin
                                m_active = 1'b0;
                            end
                        end
                    end
                    exp_o = {m_active, (m_active && m_pos == 0),
                             (m_active ? line_bit(m_pos, m_byte) : 1'b1), m_done};
                    check($sformatf("cfg%0d line {busy,rd,tx,done}", g),
                          32'({busy, fifo_rd_en, tx, tx_done}), 32'(exp_o));
                    if (rec_on) begin
                        if (tick) rec = {rec[62:0], tx};
                        if (tx_done) dcnt++;
                    end else begin
                        rec  = '0;
                        dcnt = 0;
                    end
                    fifo_empty = (fifo_q.size() == 0);
                    // Outside LOAD the read data is scrambled; it must be ignored there.
                    fifo_data  = (m_active && m_pos == 1) ? fifo_reg : DB'($urandom);
                    prev_empty = fifo_empty;
                    prev_rd    = fifo_rd_en;
                end
            end
        end

        initial begin
            forever begin
                @(posedge areset);
                #1;
                check($sformatf("cfg%0d async reset {busy,rd,tx,done}", g),
                      32'({busy, fifo_rd_en, tx, tx_done}), 32'h2);
            end
        end
    end

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick  = 1'b1;
            wr_en = 1'b0;
        end
    endtask

    // Writes b0 (and b1 one clk later if two), recording tx over nticks ticks.
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input bit two,
                         input int nticks, input int freeze_at);
        @(negedge clk);
        rec_on  = 1'b1;
        wr_en   = 1'b1;
        wr_byte = b0;
        tick    = 1'b1;
        for (int i = 1; i < nticks; i++) begin
            @(negedge clk);
            if (i == freeze_at) begin
                tick  = 1'b0;
                wr_en = 1'b0;
                repeat (100) @(negedge clk);
            end
            tick    = 1'b1;
            wr_en   = two && (i == 1);
            wr_byte = b1;
        end
        @(negedge clk);
        tick  = 1'b0;
        wr_en = 1'b0;
    endtask

    function automatic bit all_idle();
        return !g_cfg[0].busy && g_cfg[0].fifo_empty && !g_cfg[1].busy && g_cfg[1].fifo_empty &&
               !g_cfg[2].busy && g_cfg[2].fifo_empty && !g_cfg[3].busy && g_cfg[3].fifo_empty;
    endfunction

    initial begin
        int k;
        n_cmp   = 0;
        n_bad   = 0;
        areset  = 1'b1;
        tick    = 1'b0;
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        rec_on  = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b0;

        run_ticks(50);

        frame(8'hA5, 8'h00, 1'b0, 16, 0);
        check("A5 8N1 line",      32'(g_cfg[0].rec[15:0]), 32'hEA5F);
        check("A5 8E2 line",      32'(g_cfg[1].rec[15:0]), 32'hEA57);
        check("A5 8O1 line",      32'(g_cfg[2].rec[15:0]), 32'hEA5F);
        check("A5 5N2 line",      32'(g_cfg[3].rec[15:0]), 32'hEA7F);
        check("A5 8N1 done count", 32'(g_cfg[0].dcnt), 32'd1);
        rec_on = 1'b0;
        run_ticks(8);

        frame(8'h01, 8'h00, 1'b0, 16, 0);
        check("01 8N1 line", 32'(g_cfg[0].rec[15:0]), 32'hE80F);
        check("01 8E2 line", 32'(g_cfg[1].rec[15:0]), 32'hE80F);
        check("01 8O1 line", 32'(g_cfg[2].rec[15:0]), 32'hE807);
        check("01 5N2 line", 32'(g_cfg[3].rec[15:0]), 32'hE87F);
        rec_on = 1'b0;
        run_ticks(8);

        frame(8'h00, 8'hFF, 1'b1, 32, 0);
        check("00/FF 8E2 back-to-back line", 32'(g_cfg[1].rec[31:0]), 32'hE007BFDF);
        check("00/FF 8E2 done count",        32'(g_cfg[1].dcnt), 32'd2);
        check("00/FF 8N1 done count",        32'(g_cfg[0].dcnt), 32'd2);
        rec_on = 1'b0;
        run_ticks(10);
        check("00/FF 8E2 fifo ends empty", 32'(g_cfg[1].fifo_empty), 32'd1);

        // Abort 0x3C while data bit 4 is on the line.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_byte = 8'h3C;
        tick    = 1'b1;
        run_ticks(7);
        @(negedge clk);
        tick  = 1'b0;
        wr_en = 1'b0;
        #3 areset = 1'b1;
        repeat (3) @(negedge clk);
        areset = 1'b0;

        frame(8'h55, 8'h00, 1'b0, 16, 0);
        check("55 after reset 8N1 line", 32'(g_cfg[0].rec[15:0]), 32'hEAAF);
        check("55 after reset 8E2 line", 32'(g_cfg[1].rec[15:0]), 32'hEAA7);
        check("55 after reset 8O1 line", 32'(g_cfg[2].rec[15:0]), 32'hEAAF);
        check("55 after reset 5N2 line", 32'(g_cfg[3].rec[15:0]), 32'hEAFF);
        rec_on = 1'b0;
        run_ticks(8);

        frame(8'hA5, 8'h00, 1'b0, 16, 7);
        check("A5 frozen 8N1 line", 32'(g_cfg[0].rec[15:0]), 32'hEA5F);
        check("A5 frozen 8E2 line", 32'(g_cfg[1].rec[15:0]), 32'hEA57);
        check("A5 frozen 5N2 line", 32'(g_cfg[3].rec[15:0]), 32'hEA7F);
        rec_on = 1'b0;
        run_ticks(8);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tick    = ($urandom_range(0, 3) != 0);
            wr_en   = ($urandom_range(0, 19) == 0);
            wr_byte = 8'($urandom);
        end
        @(negedge clk);
        wr_en = 1'b0;
        tick  = 1'b1;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (all_idle()) break;
        end
        check("random traffic drained", 32'(k < 5000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit-side serializer that sits directly downstream of the TX FIFO (trans_fifo). It pops one byte at a time from the FIFO and drives it on the UART line as start bit, LSB-first data bits, optional parity bit and 1 or 2 stop bits, one bit per baud tick. Its busy output feeds the FIFO's busy input; its fifo_rd_en output drives the FIFO's rd_enbl input. The FIFO is clocked by the same baud tick strobe that is used here as the clock enable.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); width of fifo_data.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity (used only when PARITY_EN=1).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
areset  input  1  reset, asynchronous, active-high.
tick  input  1  one-clk-cycle baud strobe; all state transitions occur only on clk edges with tick=1.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_BITS  FIFO registered read data (temp); valid from the tick after the pop.
fifo_rd_en  output  1  pop request to the FIFO; registered.
tx  output  1  serial line; idle high.
busy  output  1  high whenever state != IDLE.
tx_done  output  1  one-clk-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (async): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, shift register=0, bit counter=0, parity accumulator=0. Applying reset mid-frame forces tx=1 immediately and abandons the frame. The FIFO is reset by the same areset.
- All outputs are registered. busy is decoded from the state register.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP. Nothing changes on a clk edge where tick=0, except that tx_done is cleared.
- IDLE: tx=1. On tick with fifo_empty=0, go to FETCH and set fifo_rd_en=1.
- FETCH: fifo_rd_en is held high for exactly one tick interval. The FIFO pops on the next tick. On that tick, go to LOAD and set fifo_rd_en=0.
- LOAD: fifo_data is now valid. On tick: shift register <= fifo_data, parity accumulator <= PARITY_ODD, tx <= 0, go to START.
- START: on tick, tx <= shift[0], shift right, parity ^= shift[0], counter=0, go to DATA.
- DATA: each tick, increment counter.
  - If counter < DATA_BITS-1, output the next bit.
  - When counter = DATA_BITS-1: if PARITY_EN, tx <= parity accumulator and go to PARITY; otherwise tx <= 1 and go to STOP with counter=0.
- PARITY: on tick, tx <= 1, go to STOP, counter=0.
- STOP: tx=1 and lasts STOP_BITS ticks. On its final tick, pulse tx_done for one clk cycle.
  - If fifo_empty=0: go to FETCH with fifo_rd_en=1 (back-to-back operation, no IDLE visit).
  - Otherwise go to IDLE.
- Line timing per frame:
  - Start bit begins 2 ticks after IDLE sees non-empty.
  - Each bit lasts exactly one tick interval.
  - Between the stop bit(s) and the next start bit there are 2 further high intervals (FETCH, LOAD).
- fifo_data is sampled only in LOAD; changes at other times are ignored.
- fifo_empty is sampled only in IDLE and at the end of STOP.
- A pop is never issued while fifo_empty=1, so FIFO underflow is impossible.
- Bit counter width is clog2(DATA_BITS). There is no wrap: the counter is reset at each state entry.

Test Plan:
- Reset with FIFO empty, 50 ticks → tx=1, busy=0, fifo_rd_en=0 and tx_done=0 throughout.
- Write 0xA5, defaults → fifo_rd_en high for one tick interval. Line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), one bit per tick. tx_done pulses once, busy drops, tx=1.
- PARITY_EN=1, 0xA5 → even parity bit 0, then stop. Rerun with PARITY_ODD=1 → parity bit 1. Also check 0x01 with even parity → parity bit 1.
- Write 0x00 then 0xFF back-to-back, STOP_BITS=2 → first frame has 2 stop ticks, then exactly 2 high ticks, then the second start bit. busy stays high across both frames; 2 tx_done pulses; FIFO ends empty.
- Assert areset during data bit 4 of 0x3C → tx=1 asynchronously, state IDLE, busy=0. After release with FIFO refilled with 0x55, a clean full frame is sent.
- Hold tick low for 100 clk mid-frame → tx, state and outputs frozen. The frame resumes exactly where it stopped when ticks restart.
